// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side memory port arbiter.
// Holds the arbiter state encoding, grant owner encoding and default bus widths.
package cpu_mem_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;
    localparam int WAIT_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side requests, memory-side strobes and responses of the port arbiter.
// The arbiter uses the slave view; whoever drives requests and models memory uses master.
interface mem_port_arbiter_if import cpu_mem_pkg::*; #(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              data_valid;
    logic [DATA_W-1:0] data_rdata;
    logic              stall_fetch;
    logic              stall_mem;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output fetch_valid, fetch_rdata, data_valid, data_rdata,
        output stall_fetch, stall_mem
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        output data_req, data_we, data_addr, data_wdata,
        output mem_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  fetch_valid, fetch_rdata, data_valid, data_rdata,
        input  stall_fetch, stall_mem
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Down-counter that times the memory read latency between ISSUE and DONE.
// Loaded once per access, decremented while waiting, saturates at zero.
module mem_wait_counter import cpu_mem_pkg::*; (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] loadValue,
    input  logic                  dec,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && !zero) begin
            count <= count - WAIT_CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// One access at a time: IDLE -> ISSUE -> WAIT -> DONE, with a fairness bit against fetch starvation.
module mem_port_arbiter import cpu_mem_pkg::*; #(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    arbState_t         state;
    owner_t            owner;
    logic              fetchFirst;
    logic              flushPending;
    logic              reqWe;
    logic              memEnQ;
    logic              memWeQ;
    logic [ADDR_W-1:0] memAddrQ;
    logic [DATA_W-1:0] memWdataQ;
    logic              fetchValidQ;
    logic              dataValidQ;
    logic [DATA_W-1:0] fetchRdataQ;
    logic [DATA_W-1:0] dataRdataQ;
    logic [DATA_W-1:0] fetchBuf;
    logic              waitZero;

    logic fetchEligible;
    logic grantData;
    logic grantFetch;
    logic flushHit;
    logic fetchDeliver;

    // A flush in the same IDLE cycle keeps the fetch out of arbitration entirely.
    assign fetchEligible = bus.fetch_req & ~bus.fetch_flush;
    assign grantData     = bus.data_req & (~fetchEligible | ~fetchFirst);
    assign grantFetch    = fetchEligible & ~grantData;
    assign flushHit      = bus.fetch_flush & (owner == OWNER_FETCH);

    mem_wait_counter u_waitCounter (
        .clk       (clk),
        .reset     (reset),
        .load      (state == ISSUE),
        .loadValue (WAIT_CNT_W'(MEM_LATENCY - 1)),
        .dec       (state == WAIT),
        .zero      (waitZero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OWNER_FETCH;
            fetchFirst   <= 1'b0;
            flushPending <= 1'b0;
            reqWe        <= 1'b0;
            memEnQ       <= 1'b0;
            memWeQ       <= 1'b0;
            memAddrQ     <= '0;
            memWdataQ    <= '0;
            fetchValidQ  <= 1'b0;
            dataValidQ   <= 1'b0;
            fetchRdataQ  <= '0;
            dataRdataQ   <= '0;
            fetchBuf     <= '0;
        end else begin
            memEnQ      <= 1'b0;
            memWeQ      <= 1'b0;
            fetchValidQ <= 1'b0;
            dataValidQ  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grantData || grantFetch) begin
                        owner      <= grantData ? OWNER_DATA : OWNER_FETCH;
                        fetchFirst <= grantData & bus.fetch_req;
                        memAddrQ   <= grantData ? bus.data_addr : bus.fetch_addr;
                        if (grantData) begin
                            memWdataQ <= bus.data_wdata;
                        end
                        reqWe  <= grantData & bus.data_we;
                        memEnQ <= 1'b1;
                        memWeQ <= grantData & bus.data_we;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (flushHit) begin
                        flushPending <= 1'b1;
                    end
                    state <= WAIT;
                end

                WAIT: begin
                    if (flushHit) begin
                        flushPending <= 1'b1;
                    end
                    if (waitZero) begin
                        if (owner == OWNER_DATA) begin
                            dataValidQ <= 1'b1;
                            if (!reqWe) begin
                                dataRdataQ <= bus.mem_rdata;
                            end
                        end else begin
                            fetchBuf    <= bus.mem_rdata;
                            fetchValidQ <= ~(flushPending | bus.fetch_flush);
                        end
                        state <= DONE;
                    end
                end

                DONE: begin
                    // The fetched word becomes architectural only if no flush arrived in DONE either.
                    if (fetchDeliver) begin
                        fetchRdataQ <= fetchBuf;
                    end
                    flushPending <= 1'b0;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // A flush landing in DONE must still kill the pulse, so the fetch result is gated here.
    assign fetchDeliver = fetchValidQ & ~bus.fetch_flush;

    assign bus.mem_en      = memEnQ;
    assign bus.mem_we      = memWeQ;
    assign bus.mem_addr    = memAddrQ;
    assign bus.mem_wdata   = memWdataQ;
    assign bus.fetch_valid = fetchDeliver;
    assign bus.fetch_rdata = fetchDeliver ? fetchBuf : fetchRdataQ;
    assign bus.data_valid  = dataValidQ;
    assign bus.data_rdata  = dataRdataQ;
    assign bus.stall_fetch = bus.fetch_req & ~bus.fetch_valid & ~bus.fetch_flush;
    assign bus.stall_mem   = bus.data_req & ~bus.data_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural memory: answers exactly L cycles after a read strobe, garbage otherwise.
    logic [15:0] memArr [logic [15:0]];
    int          rdReady = -1;
    logic [15:0] rdAddr  = '0;

    function automatic logic [15:0] memRead(input logic [15:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 16'h5A5A;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) memArr[bus.mem_addr] = bus.mem_wdata;
            else begin
                rdReady = cyc + L;
                rdAddr  = bus.mem_addr;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.mem_rdata = (cyc == rdReady) ? memRead(rdAddr) : 16'hDEAD;
    end

    // Reference model: one transaction at a time, timed from the grant cycle.
    bit          modelOn = 0;
    bit          busy = 0;
    int          gCyc = 0;
    bit          mData = 0;
    bit          mWe = 0;
    bit          mFlushed = 0;
    bit          fetchFirst = 0;
    logic [15:0] readVal = '0;
    logic [15:0] expMemAddr = '0;
    logic [15:0] expMemWdata = '0;
    logic [15:0] expFetchRdata = '0;
    logic [15:0] expDataRdata = '0;

    always @(negedge clk) begin : model
        bit expEn, expFv, expDv, fetchOk;
        int vCyc;
        vCyc = gCyc + 2 + L;
        if (modelOn) begin
            if (busy && !mData && cyc > gCyc && bus.fetch_flush) mFlushed = 1;
            expEn = busy && (cyc == gCyc + 1);
            expFv = busy && (cyc == vCyc) && !mData && !mFlushed;
            expDv = busy && (cyc == vCyc) && mData;
            if (expFv) expFetchRdata = readVal;
            if (expDv && !mWe) expDataRdata = readVal;
            check("mem_en", 32'(bus.mem_en), 32'(expEn));
            check("mem_we", 32'(bus.mem_we), 32'(expEn && mWe));
            check("mem_addr", 32'(bus.mem_addr), 32'(expMemAddr));
            if (expEn && mWe) check("mem_wdata", 32'(bus.mem_wdata), 32'(expMemWdata));
            check("fetch_valid", 32'(bus.fetch_valid), 32'(expFv));
            check("data_valid", 32'(bus.data_valid), 32'(expDv));
            check("fetch_rdata", 32'(bus.fetch_rdata), 32'(expFetchRdata));
            check("data_rdata", 32'(bus.data_rdata), 32'(expDataRdata));
            check("stall_fetch", 32'(bus.stall_fetch), 32'(bus.fetch_req && !expFv && !bus.fetch_flush));
            check("stall_mem", 32'(bus.stall_mem), 32'(bus.data_req && !expDv));
        end
        if (reset) begin
            busy = 0; fetchFirst = 0; mFlushed = 0;
            expMemAddr = '0; expMemWdata = '0; expFetchRdata = '0; expDataRdata = '0;
            modelOn = 1;
        end else if (modelOn) begin
            if (busy) begin
                if (cyc == vCyc) busy = 0;
            end else begin
                fetchOk = bus.fetch_req && !bus.fetch_flush;
                if (bus.data_req && !(fetchOk && fetchFirst)) begin
                    busy = 1; gCyc = cyc; mData = 1; mWe = bus.data_we; mFlushed = 0;
                    expMemAddr  = bus.data_addr;
                    expMemWdata = bus.data_wdata;
                    readVal     = memRead(bus.data_addr);
                    fetchFirst  = bus.fetch_req;
                end else if (fetchOk) begin
                    busy = 1; gCyc = cyc; mData = 0; mWe = 0; mFlushed = 0;
                    expMemAddr = bus.fetch_addr;
                    readVal    = memRead(bus.fetch_addr);
                    fetchFirst = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    int enCyc[$];
    logic [15:0] enAddr[$];

    initial begin
        memArr[16'h0010] = 16'hBEEF;
        memArr[16'h0200] = 16'hC0DE;
        memArr[16'h0100] = 16'h1111;
        memArr[16'h0300] = 16'h7777;
        memArr[16'h0040] = 16'hAAAA;
        memArr[16'h0400] = 16'h5555;

        reset = 1'b1;
        bus.fetch_req = 0; bus.fetch_addr = '0; bus.fetch_flush = 0;
        bus.data_req = 0; bus.data_we = 0; bus.data_addr = '0; bus.data_wdata = '0;
        bus.mem_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        atNeg();
        check("rst mem_en", 32'(bus.mem_en), 32'd0);
        check("rst fetch_rdata", 32'(bus.fetch_rdata), 32'd0);
        check("rst data_rdata", 32'(bus.data_rdata), 32'd0);
        tick();

        // Idle for 20 cycles
        repeat (20) begin
            atNeg();
            check("idle outputs", 32'({bus.mem_en, bus.fetch_valid, bus.data_valid,
                                       bus.stall_fetch, bus.stall_mem}), 32'd0);
            tick();
        end

        // Single load; a fetch request that comes and goes while busy must leave no trace
        bus.data_req = 1; bus.data_we = 0; bus.data_addr = 16'h0010; bus.fetch_addr = 16'h0ABC;
        for (int i = 0; i <= 4; i++) begin
            bus.fetch_req = (i == 2);
            atNeg();
            check("load mem_en", 32'(bus.mem_en), 32'(i == 1));
            check("load stall_mem", 32'(bus.stall_mem), 32'(i <= 3));
            check("load data_valid", 32'(bus.data_valid), 32'(i == 4));
            if (i == 1) check("load mem_addr", 32'(bus.mem_addr), 32'h0010);
            if (i == 4) check("load data_rdata", 32'(bus.data_rdata), 32'hBEEF);
            tick();
        end
        bus.data_req = 0;
        tick();

        // Store
        bus.data_req = 1; bus.data_we = 1; bus.data_addr = 16'h0020; bus.data_wdata = 16'h1234;
        for (int i = 0; i <= 4; i++) begin
            atNeg();
            if (i == 1) begin
                check("store strobes", 32'({bus.mem_en, bus.mem_we}), 32'b11);
                check("store mem_addr", 32'(bus.mem_addr), 32'h0020);
                check("store mem_wdata", 32'(bus.mem_wdata), 32'h1234);
            end
            check("store data_valid", 32'(bus.data_valid), 32'(i == 4));
            if (i == 4) check("store data_rdata kept", 32'(bus.data_rdata), 32'hBEEF);
            tick();
        end
        bus.data_req = 0; bus.data_we = 0;
        tick();

        // Normal fetch to establish fetch_rdata
        bus.fetch_req = 1; bus.fetch_addr = 16'h0200;
        for (int i = 0; i <= 4; i++) begin
            atNeg();
            if (i == 4) begin
                check("fetch valid", 32'(bus.fetch_valid), 32'd1);
                check("fetch rdata", 32'(bus.fetch_rdata), 32'hC0DE);
            end
            tick();
        end
        bus.fetch_req = 0;
        tick();

        // Fetch flushed during WAIT
        bus.fetch_req = 1; bus.fetch_addr = 16'h0100;
        for (int i = 0; i <= 6; i++) begin
            if (i == 2) begin bus.fetch_flush = 1; bus.fetch_req = 0; end
            if (i == 3) bus.fetch_flush = 0;
            atNeg();
            if (i == 1) check("flush mem_en", 32'({bus.mem_en, bus.mem_addr}), 32'h1_0100);
            check("flush no valid", 32'(bus.fetch_valid), 32'd0);
            if (i == 6) check("flush rdata kept", 32'(bus.fetch_rdata), 32'hC0DE);
            tick();
        end

        // Next fetch honoured normally
        bus.fetch_req = 1; bus.fetch_addr = 16'h0300;
        for (int i = 0; i <= 4; i++) begin
            atNeg();
            if (i == 4) check("post-flush fetch", 32'({bus.fetch_valid, bus.fetch_rdata}), 32'h1_7777);
            tick();
        end
        bus.fetch_req = 0;
        tick();

        // Flush in IDLE blocks the fetch grant
        bus.fetch_req = 1; bus.fetch_flush = 1; bus.fetch_addr = 16'h0500;
        atNeg();
        tick();
        bus.fetch_req = 0; bus.fetch_flush = 0;
        atNeg();
        check("idle flush blocks grant", 32'(bus.mem_en), 32'd0);
        tick();
        tick();

        // Contention: both held continuously
        bus.data_req = 1; bus.data_we = 0; bus.data_addr = 16'h0040;
        bus.fetch_req = 1; bus.fetch_addr = 16'h0400;
        for (int i = 0; i < 20; i++) begin
            atNeg();
            if (bus.mem_en) begin
                enCyc.push_back(cyc);
                enAddr.push_back(bus.mem_addr);
            end
            tick();
        end
        bus.data_req = 0; bus.fetch_req = 0;
        check("contention grants", 32'(enCyc.size()), 32'd4);
        if (enCyc.size() == 4) begin
            check("grant0 DATA", 32'(enAddr[0]), 32'h0040);
            check("grant1 FETCH", 32'(enAddr[1]), 32'h0400);
            check("grant2 DATA", 32'(enAddr[2]), 32'h0040);
            check("grant3 FETCH", 32'(enAddr[3]), 32'h0400);
            for (int i = 1; i < 4; i++) check("grant spacing", 32'(enCyc[i] - enCyc[i-1]), 32'd5);
        end
        repeat (6) tick();

        // Reset in the middle of WAIT during a load
        bus.data_req = 1; bus.data_we = 0; bus.data_addr = 16'h0010;
        tick();
        tick();
        reset = 1; bus.data_req = 0;
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            atNeg();
            check("post-reset quiet", 32'({bus.mem_en, bus.mem_we, bus.fetch_valid, bus.data_valid,
                                           bus.stall_fetch, bus.stall_mem}), 32'd0);
            check("post-reset regs", 32'({bus.mem_addr, bus.data_rdata}), 32'd0);
            tick();
        end

        // Fresh load with standard latency
        bus.data_req = 1; bus.data_addr = 16'h0010;
        for (int i = 0; i <= 4; i++) begin
            atNeg();
            check("fresh load mem_en", 32'(bus.mem_en), 32'(i == 1));
            check("fresh load valid", 32'(bus.data_valid), 32'(i == 4));
            if (i == 4) check("fresh load rdata", 32'(bus.data_rdata), 32'hBEEF);
            tick();
        end
        bus.data_req = 0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
